// File: rtl/xy_route_ctrl.sv
// Dimension-ordered (XY / YX) route controller for a single mesh router input.
// Routes a packet from its head flit and forwards it through a one-entry output register.
module xy_route_ctrl #(
    parameter int COL_CORD          = 0,
    parameter int ROW_CORD          = 0,
    parameter int PACKET_ADDR_COL_W = 4,
    parameter int PACKET_ADDR_ROW_W = 4,
    parameter int OUTPUT_N_W        = 3,
    parameter int FLIT_DATA_W       = 8,
    parameter int ROUTE_MODE        = 0,
    parameter int PKT_CNT_W         = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FLIT_DATA_W+1:0]  flit_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FLIT_DATA_W+1:0]  flit_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [OUTPUT_N_W-1:0]   out_chan_sel_o,
    output logic                    err_o,
    output logic [PKT_CNT_W-1:0]    pkt_cnt_o
);

    localparam int FLIT_W = FLIT_DATA_W + 2;

    localparam logic [PACKET_ADDR_COL_W-1:0] COL_HERE = PACKET_ADDR_COL_W'(COL_CORD);
    localparam logic [PACKET_ADDR_ROW_W-1:0] ROW_HERE = PACKET_ADDR_ROW_W'(ROW_CORD);

    localparam logic [OUTPUT_N_W-1:0] PORT_RESOURCE = OUTPUT_N_W'(0);
    localparam logic [OUTPUT_N_W-1:0] PORT_LEFT     = OUTPUT_N_W'(1);
    localparam logic [OUTPUT_N_W-1:0] PORT_UP       = OUTPUT_N_W'(2);
    localparam logic [OUTPUT_N_W-1:0] PORT_RIGHT    = OUTPUT_N_W'(3);
    localparam logic [OUTPUT_N_W-1:0] PORT_DOWN     = OUTPUT_N_W'(4);

    typedef enum logic [1:0] {
        TYPE_BODY     = 2'b00,
        TYPE_TAIL     = 2'b01,
        TYPE_HEAD     = 2'b10,
        TYPE_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_e;

    // The address fields must fit inside the payload.
    if (FLIT_DATA_W < PACKET_ADDR_COL_W + PACKET_ADDR_ROW_W) begin : g_bad_width
        $error("xy_route_ctrl: FLIT_DATA_W too small for destination address");
    end

    state_e                   state_reg;
    state_e                   state_next;
    logic [FLIT_W-1:0]        flit_reg;
    logic                     valid_reg;
    logic [OUTPUT_N_W-1:0]    route_reg;
    logic [OUTPUT_N_W-1:0]    route_next;
    logic                     err_reg;
    logic [PKT_CNT_W-1:0]     cnt_reg;

    flit_type_e               flit_type;
    logic [PACKET_ADDR_COL_W-1:0] dst_col;
    logic [PACKET_ADDR_ROW_W-1:0] dst_row;
    logic                     accept;
    logic                     fwd;
    logic                     drop;
    logic                     pkt_done;
    logic                     load_route;

    assign flit_type = flit_type_e'(flit_i[FLIT_W-1 -: 2]);
    assign dst_col   = flit_i[PACKET_ADDR_COL_W-1:0];
    assign dst_row   = flit_i[PACKET_ADDR_COL_W +: PACKET_ADDR_ROW_W];

    // Output register is free when empty or being drained this cycle.
    assign ready_o = !valid_reg || ready_i;
    assign accept  = valid_i && ready_o;

    if (ROUTE_MODE == 0) begin : g_xy
        always_comb begin
            route_next = PORT_RESOURCE;
            if (dst_col > COL_HERE)
                route_next = PORT_RIGHT;
            else if (dst_col < COL_HERE)
                route_next = PORT_LEFT;
            else if (dst_row < ROW_HERE)
                route_next = PORT_UP;
            else if (dst_row > ROW_HERE)
                route_next = PORT_DOWN;
        end
    end else begin : g_yx
        always_comb begin
            route_next = PORT_RESOURCE;
            if (dst_row < ROW_HERE)
                route_next = PORT_UP;
            else if (dst_row > ROW_HERE)
                route_next = PORT_DOWN;
            else if (dst_col > COL_HERE)
                route_next = PORT_RIGHT;
            else if (dst_col < COL_HERE)
                route_next = PORT_LEFT;
        end
    end

    always_comb begin
        state_next = state_reg;
        fwd        = 1'b0;
        drop       = 1'b0;
        pkt_done   = 1'b0;
        load_route = 1'b0;
        if (accept) begin
            case (state_reg)
                IDLE: begin
                    case (flit_type)
                        TYPE_HEAD: begin
                            fwd        = 1'b1;
                            load_route = 1'b1;
                            state_next = PKT;
                        end
                        TYPE_HEADTAIL: begin
                            fwd        = 1'b1;
                            load_route = 1'b1;
                            pkt_done   = 1'b1;
                        end
                        default: drop = 1'b1;
                    endcase
                end
                PKT: begin
                    case (flit_type)
                        TYPE_BODY: fwd = 1'b1;
                        TYPE_TAIL: begin
                            fwd        = 1'b1;
                            pkt_done   = 1'b1;
                            state_next = IDLE;
                        end
                        default: drop = 1'b1;
                    endcase
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Dropped flits still drain the register when ready_i is high, so valid falls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            flit_reg  <= '0;
            valid_reg <= 1'b0;
            route_reg <= PORT_RESOURCE;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= drop;
            if (fwd) begin
                flit_reg  <= flit_i;
                valid_reg <= 1'b1;
            end else if (ready_i) begin
                valid_reg <= 1'b0;
            end
            if (load_route)
                route_reg <= route_next;
            if (pkt_done)
                cnt_reg <= cnt_reg + PKT_CNT_W'(1);
        end
    end

    assign flit_o         = flit_reg;
    assign valid_o        = valid_reg;
    assign out_chan_sel_o = route_reg;
    assign err_o          = err_reg;
    assign pkt_cnt_o      = cnt_reg;

endmodule

// File: tb/tb_xy_route_ctrl.sv
// Scoreboard bench for xy_route_ctrl: an XY and a YX instance at (1,1) share stimulus;
// directed flits push hand-computed expectations, a monitor pops them on output transfers.
module tb_xy_route_ctrl;

    localparam int FW = 10;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b01;
    localparam logic [1:0] T_HEAD = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flit_i;
    logic          valid_i;
    logic          ready_i;

    logic          xy_ready, yx_ready;
    logic [FW-1:0] xy_flit, yx_flit;
    logic          xy_valid, yx_valid;
    logic [2:0]    xy_sel, yx_sel;
    logic          xy_err, yx_err;
    logic [1:0]    xy_cnt, yx_cnt;

    typedef struct {
        logic [FW-1:0] flit;
        logic [2:0]    sel;
        logic [1:0]    cnt;
    } exp_t;

    exp_t q_xy[$];
    exp_t q_yx[$];
    int   err_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    xy_route_ctrl #(
        .COL_CORD(1), .ROW_CORD(1), .PACKET_ADDR_COL_W(4), .PACKET_ADDR_ROW_W(4),
        .OUTPUT_N_W(3), .FLIT_DATA_W(8), .ROUTE_MODE(0), .PKT_CNT_W(2)
    ) dut_xy (
        .clk_i(clk), .rst_i(rst), .flit_i(flit_i), .valid_i(valid_i), .ready_o(xy_ready),
        .flit_o(xy_flit), .valid_o(xy_valid), .ready_i(ready_i), .out_chan_sel_o(xy_sel),
        .err_o(xy_err), .pkt_cnt_o(xy_cnt)
    );

    xy_route_ctrl #(
        .COL_CORD(1), .ROW_CORD(1), .PACKET_ADDR_COL_W(4), .PACKET_ADDR_ROW_W(4),
        .OUTPUT_N_W(3), .FLIT_DATA_W(8), .ROUTE_MODE(1), .PKT_CNT_W(2)
    ) dut_yx (
        .clk_i(clk), .rst_i(rst), .flit_i(flit_i), .valid_i(valid_i), .ready_o(yx_ready),
        .flit_o(yx_flit), .valid_o(yx_valid), .ready_i(ready_i), .out_chan_sel_o(yx_sel),
        .err_o(yx_err), .pkt_cnt_o(yx_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one flit and wait for acceptance; fwd=0 means the DUT must drop it.
    task automatic send(input logic [1:0] t, input logic [3:0] col, input logic [3:0] row,
                        input bit fwd, input logic [2:0] sel_xy, input logic [2:0] sel_yx,
                        input logic [1:0] cnt);
        int n;
        bit ok;
        exp_t e;
        flit_i  = {t, row, col};
        valid_i = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (xy_ready && yx_ready) ok = 1'b1;
            else n++;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: flit %0h never accepted", flit_i);
        end else if (fwd) begin
            e.flit = flit_i; e.sel = sel_xy; e.cnt = cnt;
            q_xy.push_back(e);
            e.sel = sel_yx;
            q_yx.push_back(e);
        end else begin
            err_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        $display("sent flit %0h fwd=%0d", {t, row, col}, fwd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, xy_valid, 0);
        check({tag, "_flit"},  xy_flit,  0);
        check({tag, "_sel"},   xy_sel,   0);
        check({tag, "_err"},   xy_err,   0);
        check({tag, "_cnt"},   xy_cnt,   0);
        check({tag, "_yx_valid"}, yx_valid, 0);
        check({tag, "_yx_sel"},   yx_sel,   0);
    endtask

    // Monitor: err pulses, stall stability, and scoreboard pops on output transfers.
    initial begin
        bit            stall_prev;
        bit            exp_err;
        logic [FW-1:0] held;
        exp_t          e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
                if (exp_err) void'(err_q.pop_front());
                if (xy_err || yx_err || exp_err) begin
                    check("err_xy", xy_err, exp_err);
                    check("err_yx", yx_err, exp_err);
                end
                if (stall_prev) begin
                    check("stall_valid", xy_valid, 1);
                    check("stall_flit", xy_flit, held);
                end
                if (xy_valid && !ready_i) begin
                    check("stall_ready", xy_ready, 0);
                    stall_prev = 1'b1;
                    held = xy_flit;
                end else begin
                    stall_prev = 1'b0;
                end
                if (xy_valid && ready_i) begin
                    if (q_xy.size() == 0) begin
                        check("unexpected_out_xy", xy_flit, 0);
                        if (xy_flit == 0) begin
                            errors++;
                            $display("FAIL unexpected_out_xy: got flit 0 expected no output");
                        end
                    end else begin
                        e = q_xy.pop_front();
                        check("xy_flit", xy_flit, e.flit);
                        check("xy_sel",  xy_sel,  e.sel);
                        check("xy_cnt",  xy_cnt,  e.cnt);
                        $display("out xy flit %0h sel %0d cnt %0d", xy_flit, xy_sel, xy_cnt);
                    end
                end
                if (yx_valid && ready_i) begin
                    if (q_yx.size() == 0) begin
                        check("unexpected_out_yx", yx_flit, 0);
                        if (yx_flit == 0) begin
                            errors++;
                            $display("FAIL unexpected_out_yx: got flit 0 expected no output");
                        end
                    end else begin
                        e = q_yx.pop_front();
                        check("yx_flit", yx_flit, e.flit);
                        check("yx_sel",  yx_sel,  e.sel);
                        check("yx_cnt",  yx_cnt,  e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        flit_i  = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_ready", xy_ready, 1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back single-flit packets: routing for both modes and 2-bit counter wrap.
        send(T_HT, 4'd3, 4'd0, 1, 3'd3, 3'd2, 2'd1);
        send(T_HT, 4'd1, 4'd1, 1, 3'd0, 3'd0, 2'd2);
        send(T_HT, 4'd1, 4'd2, 1, 3'd4, 3'd4, 2'd3);
        send(T_HT, 4'd0, 4'd1, 1, 3'd1, 3'd1, 2'd0);
        send(T_HT, 4'd2, 4'd3, 1, 3'd3, 3'd4, 2'd1);

        // BODY with no open packet is dropped.
        send(T_BODY, 4'h7, 4'h7, 0, 3'd0, 3'd0, 2'd1);

        // Multi-flit packet with a 3-cycle downstream stall after the head.
        send(T_HEAD, 4'd0, 4'd0, 1, 3'd1, 3'd2, 2'd1);
        ready_i = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join_none
        send(T_BODY, 4'hA, 4'h5, 1, 3'd1, 3'd2, 2'd1);
        send(T_HEAD, 4'd3, 4'd3, 0, 3'd1, 3'd2, 2'd1);
        send(T_BODY, 4'h3, 4'hC, 1, 3'd1, 3'd2, 2'd1);
        send(T_TAIL, 4'hF, 4'h0, 1, 3'd1, 3'd2, 2'd2);

        // Reset in the middle of a packet while the head is still held.
        send(T_HEAD, 4'd2, 4'd1, 1, 3'd3, 3'd3, 2'd2);
        ready_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midpkt_reset");
        q_xy.delete();
        q_yx.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        send(T_TAIL, 4'h1, 4'h1, 0, 3'd0, 3'd0, 2'd0);
        send(T_HT, 4'd1, 4'd0, 1, 3'd2, 3'd2, 2'd1);

        repeat (5) @(negedge clk);
        check("q_xy_drained", q_xy.size(), 0);
        check("q_yx_drained", q_yx.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xy_route_ctrl.md
XY_ROUTE_CTRL -- requirements
Module: xy_route_ctrl

Interface
REQ-001 Parameter COL_CORD, 0: column coordinate of this router.
REQ-002 Parameter ROW_CORD, 0: row coordinate of this router.
REQ-003 Parameter PACKET_ADDR_COL_W, 4: destination column address width.
REQ-004 Parameter PACKET_ADDR_ROW_W, 4: destination row address width.
REQ-005 Parameter OUTPUT_N_W, 3: output channel select width.
REQ-006 Parameter FLIT_DATA_W, 8: flit payload width; shall be >= PACKET_ADDR_COL_W+PACKET_ADDR_ROW_W.
REQ-007 Parameter ROUTE_MODE, 0: 0 = XY (column first), 1 = YX (row first).
REQ-008 Parameter PKT_CNT_W, 8: completed-packet counter width.
REQ-009 clk_i  in  1  single clock; all state updates on rising edge.
REQ-010 rst_i  in  1  reset, asynchronous, active-high.
REQ-011 flit_i  in  FLIT_DATA_W+2  [MSB:MSB-1] flit type (10 HEAD, 00 BODY, 01 TAIL, 11 HEADTAIL); [PACKET_ADDR_COL_W-1:0] destination column; next PACKET_ADDR_ROW_W bits destination row (head types only).
REQ-012 valid_i  in  1  flit_i valid.
REQ-013 ready_o  out  1  block accepts flit_i this cycle.
REQ-014 flit_o  out  FLIT_DATA_W+2  registered forwarded flit.
REQ-015 valid_o  out  1  flit_o valid.
REQ-016 ready_i  in  1  downstream accepts flit_o.
REQ-017 out_chan_sel_o  out  OUTPUT_N_W  output port for the current packet.
REQ-018 err_o  out  1  one-cycle pulse on protocol error.
REQ-019 pkt_cnt_o  out  PKT_CNT_W  number of completed packets forwarded.

Function
REQ-020 Port IDs: RESOURCE=0, LEFT=1, UP=2, RIGHT=3, DOWN=4; coordinates are truncated to the address widths before comparison.
REQ-021 XY mode: col_dst>COL_CORD -> RIGHT; col_dst<COL_CORD -> LEFT; columns equal: row_dst<ROW_CORD -> UP, row_dst>ROW_CORD -> DOWN, both equal -> RESOURCE.
REQ-022 YX mode: rows compared first (UP/DOWN), then columns (RIGHT/LEFT), RESOURCE when both equal.
REQ-023 Handshake: transfer on valid&ready; ready_o = !valid_o | ready_i (one-entry pipeline register, full throughput, 1-cycle latency).
REQ-024 valid_o/flit_o shall hold stable while valid_o=1 and ready_i=0.
REQ-025 FSM states IDLE and PKT; reset state IDLE.
REQ-026 IDLE, accepted HEAD: latch route into out_chan_sel_o, load output register, go PKT.
REQ-027 IDLE, accepted HEADTAIL: latch route, load output register, stay IDLE, increment pkt_cnt_o.
REQ-028 IDLE, accepted BODY/TAIL: drop flit (not forwarded), err_o=1 next cycle, stay IDLE.
REQ-029 PKT, accepted BODY: forward, route unchanged.
REQ-030 PKT, accepted TAIL: forward, go IDLE, increment pkt_cnt_o.
REQ-031 PKT, accepted HEAD/HEADTAIL: drop, err_o pulse, stay PKT, route unchanged.
REQ-032 out_chan_sel_o shall change only on an accepted head-type flit in IDLE and hold until the next such flit.
REQ-033 pkt_cnt_o wraps from 2^PKT_CNT_W-1 to 0.
REQ-034 Dropped flits are always accepted (ready_o rule unchanged) and never set valid_o.
REQ-035 Simultaneous output drain and input accept in the same cycle shall replace the register contents with no bubble.

Reset
REQ-036 While rst_i=1, asynchronously: state IDLE, valid_o=0, flit_o=0, out_chan_sel_o=0 (RESOURCE), err_o=0, pkt_cnt_o=0.
REQ-037 Reset mid-packet discards the held flit and the partial packet; the first post-reset flit must be a head type.

Verification
REQ-038 COL_CORD=1,ROW_CORD=1,XY; HEADTAIL dst (col 3,row 0), ready_i=1 -> next cycle valid_o=1, out_chan_sel_o=3, pkt_cnt_o=1.
REQ-039 Same flit with ROUTE_MODE=1 -> out_chan_sel_o=2; dst (1,1) -> 0; dst (1,2) -> 4; dst (0,1) -> 1.
REQ-040 HEAD, BODY, BODY, TAIL with ready_i=0 for 3 cycles after HEAD -> ready_o=0 while valid_o=1, flit_o stable, all 4 flits delivered in order, route constant, pkt_cnt_o=1.
REQ-041 BODY in IDLE -> err_o=1 for exactly one cycle, valid_o stays 0; HEAD during PKT -> err_o pulse, route unchanged.
REQ-042 rst_i asserted between HEAD and TAIL -> outputs at reset values immediately; following TAIL dropped with err_o pulse.
REQ-043 PKT_CNT_W=2, 5 HEADTAIL packets -> pkt_cnt_o sequence 1,2,3,0,1.
